fetch_decode_unit: RTL and testbench
====================================

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, byte increment per issued instruction.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  64  byte address of requested instruction (= PC).
REQ-007 imem_ack  input  1  memory has valid imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  downstream datapath cannot accept the issued instruction.
REQ-010 dec_valid  output  1  decoded control fields valid this cycle.
REQ-011 register_1, register_2, write_register  output  6 each  rs1, rs2, rd; bit 5 always 0.
REQ-012 imm  output  12  I-type immediate, instr[31:20].
REQ-013 ALUSrc  output  1  1 selects imm as ALU operand B.
REQ-014 RegWrite  output  1  write-back enable.
REQ-015 ALU_CO  output  4  ALU operation code.
REQ-016 pc_out  output  64  PC of the instruction in the issue slot.
REQ-017 illegal_instr  output  1  issued word is not a supported R/I-type instruction.

Function
REQ-018 FSM states: FETCH, ISSUE, HALT (HALT reachable only per REQ-033).
REQ-019 FETCH: imem_req=1, imem_addr=PC, dec_valid=0; on posedge with imem_ack=1 register all decoded fields and pc_out=PC, go to ISSUE; without ack remain in FETCH, PC unchanged.
REQ-020 ISSUE: imem_req=0, dec_valid=1, all outputs held stable; on posedge with stall=0 set PC=PC+PC_STEP (64-bit wrap modulo 2^64) and go to FETCH; with stall=1 stay in ISSUE.
REQ-021 Latency: dec_valid asserts the cycle after imem_ack is sampled; minimum throughput one instruction per 2 cycles.
REQ-022 imem_ack while not in FETCH is ignored.
REQ-023 R-type (opcode 7'b0110011): ALUSrc=0, RegWrite=1; funct7/funct3 map: 0000000/000 ADD=4'b0010, 0100000/000 SUB=4'b0110, 0000000/111 AND=4'b0000, 0000000/110 OR=4'b0001, 0000000/100 XOR=4'b0011, 0000000/001 SLL=4'b0100, 0000000/101 SRL=4'b0101.
REQ-024 I-type (opcode 7'b0010011): ALUSrc=1, RegWrite=1, register_2=0; funct3 000 ADDI=ADD, 111 ANDI=AND, 110 ORI=OR, 100 XORI=XOR.
REQ-025 Any other opcode/funct combination: illegal_instr=1, RegWrite=0, ALUSrc=0, ALU_CO=4'b0010, still issued with dec_valid=1.
REQ-026 write_register=0 forces RegWrite=0 (x0 never written); illegal_instr unaffected.
REQ-027 imm always carries instr[31:20], also for R-type; sign extension is downstream's job.
REQ-028 Control outputs are registered; no combinational path from imem_rdata or stall to any output.

Reset
REQ-029 rst_n=0 immediately (asynchronously) forces: state=FETCH, PC=RESET_PC, pc_out=RESET_PC, dec_valid=0, imem_req=0, RegWrite=0, ALUSrc=0, illegal_instr=0, ALU_CO=0, register_1/2, write_register, imm=0.
REQ-030 imem_req held 0 while rst_n=0; asserts in first cycle after release with imem_addr=RESET_PC.
REQ-031 Reset during ISSUE or FETCH discards the in-flight instruction; PC does not advance.

Configuration
REQ-032 Macro HALT_ON_ILLEGAL_EN selects illegal-instruction handling.
REQ-033 Defined: from ISSUE with illegal_instr=1 and stall=0, go to HALT instead of FETCH; HALT holds PC, imem_req=0, dec_valid=0, illegal_instr=1 until reset.
REQ-034 Undefined: HALT state not implemented; illegal instructions issue as NOPs and fetch continues per REQ-020.

Verification
REQ-035 Reset release, imem_ack=1 every cycle, words ADD x3,x1,x2 then ADDI x5,x0,-1 -> imem_addr 0 then 4; first issue ALU_CO=0010 ALUSrc=0 RegWrite=1 rd=3; second ALUSrc=1 imm=12'hFFF rd=5; dec_valid on cycles 2 and 4.
REQ-036 SUB issued, stall=1 for 3 cycles -> dec_valid and all fields stable 4 cycles, imem_req=0, PC advances to 4 only after stall drops.
REQ-037 imem_ack withheld 5 cycles -> imem_req=1 and imem_addr constant 5 cycles, dec_valid=0 throughout.
REQ-038 Word 32'h00000003 (load opcode) -> illegal_instr=1, RegWrite=0; with HALT_ON_ILLEGAL_EN imem_req stays 0 after issue; without, next fetch at PC+4.
REQ-039 ADD x0,x1,x2 -> RegWrite=0, illegal_instr=0; RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 0.
REQ-040 rst_n pulsed low mid-ISSUE -> outputs clear asynchronously before next edge; refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit
//
// Two-phase instruction front end. In FETCH it requests the word at PC from
// instruction memory; when the memory acknowledges, the word is decoded and
// every control field is captured into registers. ISSUE then presents those
// registered fields with dec_valid=1 until the downstream datapath accepts
// them (stall=0). After acceptance, PC advances by PC_STEP and the next
// fetch begins.
//
// Optional feature (compile-time macro HALT_ON_ILLEGAL_EN):
//   defined   - an accepted illegal instruction parks the unit in HALT
//               until reset (no further fetches, illegal_instr kept high).
//   undefined - illegal instructions issue as NOPs and fetching continues.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_STEP   byte increment per accepted instruction
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req / imem_addr       fetch request and byte address (= PC)
//   imem_ack / imem_rdata      memory response and instruction word
//   stall                      downstream cannot take the issued instruction
//   dec_valid                  decoded fields valid this cycle
//   register_1/2, write_register  rs1, rs2, rd (bit 5 always 0)
//   imm                        instr[31:20], unextended
//   ALUSrc, RegWrite, ALU_CO   ALU operand select, write enable, ALU op
//   pc_out                     PC of the instruction in the issue slot
//   illegal_instr              issued word is not a supported R/I-type op
// ---------------------------------------------------------------------------
module fetch_decode_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic        dec_valid,
    output logic [5:0]  register_1,
    output logic [5:0]  register_2,
    output logic [5:0]  write_register,
    output logic [11:0] imm,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [3:0]  ALU_CO,
    output logic [63:0] pc_out,
    output logic        illegal_instr
);

    localparam logic [63:0] LP_STEP  = 64'(PC_STEP);
    localparam logic [6:0]  OP_RTYPE = 7'b0110011;
    localparam logic [6:0]  OP_ITYPE = 7'b0010011;

    localparam logic [3:0]  ALU_AND  = 4'b0000;
    localparam logic [3:0]  ALU_OR   = 4'b0001;
    localparam logic [3:0]  ALU_ADD  = 4'b0010;
    localparam logic [3:0]  ALU_XOR  = 4'b0011;
    localparam logic [3:0]  ALU_SLL  = 4'b0100;
    localparam logic [3:0]  ALU_SRL  = 4'b0101;
    localparam logic [3:0]  ALU_SUB  = 4'b0110;

`ifdef HALT_ON_ILLEGAL_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1
    } state_t;
`endif

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_pcOut;
    logic        r_decValid;
    logic [5:0]  r_rs1;
    logic [5:0]  r_rs2;
    logic [5:0]  r_rd;
    logic [11:0] r_imm;
    logic        r_aluSrc;
    logic        r_regWrite;
    logic [3:0]  r_aluCo;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_legal;
    logic        w_aluSrc;
    logic [3:0]  w_aluCo;
    logic [5:0]  w_rs2;
    logic        w_regWrite;

    // Decoder for the word currently on imem_rdata. Only its registered copy
    // ever reaches the outputs, so nothing here is visible combinationally.
    // Unsupported encodings fall back to an ADD-coded NOP with no write-back.
    always_comb begin
        w_opcode = imem_rdata[6:0];
        w_funct3 = imem_rdata[14:12];
        w_funct7 = imem_rdata[31:25];
        w_legal  = 1'b0;
        w_aluSrc = 1'b0;
        w_aluCo  = ALU_ADD;
        w_rs2    = {1'b0, imem_rdata[24:20]};

        if (w_opcode == OP_RTYPE) begin
            w_legal = 1'b1;
            case ({w_funct7, w_funct3})
                {7'b0000000, 3'b000}: w_aluCo = ALU_ADD;
                {7'b0100000, 3'b000}: w_aluCo = ALU_SUB;
                {7'b0000000, 3'b111}: w_aluCo = ALU_AND;
                {7'b0000000, 3'b110}: w_aluCo = ALU_OR;
                {7'b0000000, 3'b100}: w_aluCo = ALU_XOR;
                {7'b0000000, 3'b001}: w_aluCo = ALU_SLL;
                {7'b0000000, 3'b101}: w_aluCo = ALU_SRL;
                default: begin
                    w_legal = 1'b0;
                    w_aluCo = ALU_ADD;
                end
            endcase
        end else if (w_opcode == OP_ITYPE) begin
            // Legal immediate forms carry no rs2; the rs2 bit positions are imm.
            w_legal  = 1'b1;
            w_aluSrc = 1'b1;
            w_rs2    = 6'd0;
            case (w_funct3)
                3'b000:  w_aluCo = ALU_ADD;
                3'b111:  w_aluCo = ALU_AND;
                3'b110:  w_aluCo = ALU_OR;
                3'b100:  w_aluCo = ALU_XOR;
                default: begin
                    w_legal  = 1'b0;
                    w_aluSrc = 1'b0;
                    w_aluCo  = ALU_ADD;
                    w_rs2    = {1'b0, imem_rdata[24:20]};
                end
            endcase
        end

        // x0 is hard-wired zero, so writes to it are suppressed here.
        w_regWrite = w_legal && (imem_rdata[11:7] != 5'd0);
    end

    // Fetch/issue controller. All decoded fields are captured on the
    // acknowledged fetch and then held untouched for the whole issue slot,
    // however long the downstream stall lasts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_pcOut    <= RESET_PC;
            r_decValid <= 1'b0;
            r_rs1      <= 6'd0;
            r_rs2      <= 6'd0;
            r_rd       <= 6'd0;
            r_imm      <= 12'd0;
            r_aluSrc   <= 1'b0;
            r_regWrite <= 1'b0;
            r_aluCo    <= 4'd0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state    <= S_ISSUE;
                        r_decValid <= 1'b1;
                        r_pcOut    <= r_pc;
                        r_rs1      <= {1'b0, imem_rdata[19:15]};
                        r_rs2      <= w_rs2;
                        r_rd       <= {1'b0, imem_rdata[11:7]};
                        r_imm      <= imem_rdata[31:20];
                        r_aluSrc   <= w_aluSrc;
                        r_regWrite <= w_regWrite;
                        r_aluCo    <= w_aluCo;
                        r_illegal  <= !w_legal;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        r_decValid <= 1'b0;
`ifdef HALT_ON_ILLEGAL_EN
                        // An accepted illegal word freezes the PC on itself.
                        if (r_illegal) begin
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                            r_pc    <= r_pc + LP_STEP;
                        end
`else
                        r_state <= S_FETCH;
                        r_pc    <= r_pc + LP_STEP;
`endif
                    end
                end
`ifdef HALT_ON_ILLEGAL_EN
                S_HALT: begin
                    r_state    <= S_HALT;
                    r_decValid <= 1'b0;
                end
`endif
                default: begin
                    r_state    <= S_FETCH;
                    r_decValid <= 1'b0;
                end
            endcase
        end
    end

    // The request is gated by rst_n so it stays low throughout reset and
    // rises in the very first cycle after release.
    assign imem_req       = rst_n && (r_state == S_FETCH);
    assign imem_addr      = r_pc;
    assign dec_valid      = r_decValid;
    assign register_1     = r_rs1;
    assign register_2     = r_rs2;
    assign write_register = r_rd;
    assign imm            = r_imm;
    assign ALUSrc         = r_aluSrc;
    assign RegWrite       = r_regWrite;
    assign ALU_CO         = r_aluCo;
    assign pc_out         = r_pcOut;
    assign illegal_instr  = r_illegal;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Testbench for fetch_decode_unit: directed sequences followed by random
// memory/stall/reset traffic, compared every cycle against a transaction
// level reference model. A second instance with a near-top RESET_PC checks
// the 64-bit PC wrap.
module tb_fetch_decode_unit;

   localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_ack;
   logic        stall;
   logic [31:0] imem_rdata;

   logic        imem_req;
   logic [63:0] imem_addr;
   logic        dec_valid;
   logic [5:0]  register_1, register_2, write_register;
   logic [11:0] imm;
   logic        ALUSrc, RegWrite;
   logic [3:0]  ALU_CO;
   logic [63:0] pc_out;
   logic        illegal_instr;

   logic        wImemReq;
   logic [63:0] wImemAddr;
   logic        wDecValid;
   logic [5:0]  wReg1, wReg2, wRd;
   logic [11:0] wImm;
   logic        wAluSrc, wRegWrite;
   logic [3:0]  wAluCo;
   logic [63:0] wPcOut;
   logic        wIllegal;

   int checkCount = 0;
   int errorCount = 0;

   fetch_decode_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .dec_valid(dec_valid),
      .register_1(register_1), .register_2(register_2), .write_register(write_register),
      .imm(imm), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALU_CO(ALU_CO),
      .pc_out(pc_out), .illegal_instr(illegal_instr)
   );

   fetch_decode_unit #(.RESET_PC(WRAP_PC)) dutWrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req(wImemReq), .imem_addr(wImemAddr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .dec_valid(wDecValid),
      .register_1(wReg1), .register_2(wReg2), .write_register(wRd),
      .imm(wImm), .ALUSrc(wAluSrc), .RegWrite(wRegWrite), .ALU_CO(wAluCo),
      .pc_out(wPcOut), .illegal_instr(wIllegal)
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  rs1;
      logic [5:0]  rs2;
      logic [5:0]  rd;
      logic [11:0] imm;
      logic        aluSrc;
      logic        regWrite;
      logic [3:0]  aluCo;
      logic        illegal;
   } fields_t;

   typedef struct packed {
      logic       isImm;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [3:0] code;
   } opEntry_t;

   // Reference model state: an instruction is either being fetched, sitting
   // in the issue slot, or the unit has halted.
   logic        mIssuing;
   logic        mHalted;
   logic [63:0] mPc;
   logic [63:0] mPcOut;
   fields_t     mF;

   // Supported operations; entries 0-6 are register forms, 7-10 immediate.
   function automatic opEntry_t entryAt(input int i);
      opEntry_t e;
      case (i)
         0:       e = '{1'b0, 7'h00, 3'd0, 4'b0010};
         1:       e = '{1'b0, 7'h20, 3'd0, 4'b0110};
         2:       e = '{1'b0, 7'h00, 3'd7, 4'b0000};
         3:       e = '{1'b0, 7'h00, 3'd6, 4'b0001};
         4:       e = '{1'b0, 7'h00, 3'd4, 4'b0011};
         5:       e = '{1'b0, 7'h00, 3'd1, 4'b0100};
         6:       e = '{1'b0, 7'h00, 3'd5, 4'b0101};
         7:       e = '{1'b1, 7'h00, 3'd0, 4'b0010};
         8:       e = '{1'b1, 7'h00, 3'd7, 4'b0000};
         9:       e = '{1'b1, 7'h00, 3'd6, 4'b0001};
         default: e = '{1'b1, 7'h00, 3'd4, 4'b0011};
      endcase
      return e;
   endfunction

   // Expected decode: search the operation table for a matching encoding.
   function automatic fields_t refDecode(input logic [31:0] w);
      fields_t  f;
      opEntry_t e;
      logic     hit;
      f.rs1      = {1'b0, w[19:15]};
      f.rs2      = {1'b0, w[24:20]};
      f.rd       = {1'b0, w[11:7]};
      f.imm      = w[31:20];
      f.aluSrc   = 1'b0;
      f.aluCo    = 4'b0010;
      f.illegal  = 1'b1;
      for (int i = 0; i < 11; i++) begin
         e = entryAt(i);
         if (e.isImm)
            hit = (w[6:0] == 7'h13) && (w[14:12] == e.f3);
         else
            hit = (w[6:0] == 7'h33) && (w[14:12] == e.f3) && (w[31:25] == e.f7);
         if (hit) begin
            f.illegal = 1'b0;
            f.aluCo   = e.code;
            f.aluSrc  = e.isImm;
            if (e.isImm) f.rs2 = 6'd0;
         end
      end
      f.regWrite = !f.illegal && (w[11:7] != 5'd0);
      return f;
   endfunction

   function automatic logic [31:0] makeR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] makeI(input logic [11:0] im, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {im, rs1, f3, rd, 7'h13};
   endfunction

   // Random instruction mix: legal register/immediate ops, near-miss
   // encodings with the right opcode, and arbitrary words; rd=0 now and then.
   function automatic logic [31:0] genWord();
      logic [31:0] w;
      opEntry_t    e;
      int          kind;
      w    = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
         e = entryAt($urandom_range(0, 6));
         w[31:25] = e.f7;
         w[14:12] = e.f3;
         w[6:0]   = 7'h33;
      end else if (kind <= 6) begin
         e = entryAt($urandom_range(7, 10));
         w[14:12] = e.f3;
         w[6:0]   = 7'h13;
      end else if (kind == 7) begin
         if ($urandom_range(0, 1) == 0) w[31:25] = 7'h00;
         w[6:0] = 7'h33;
      end else if (kind == 8) begin
         w[6:0] = 7'h13;
      end
      if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mIssuing = 1'b0;
      mHalted  = 1'b0;
      mPc      = 64'd0;
      mPcOut   = 64'd0;
      mF       = '0;
   endtask

   // Advance the model across one rising edge using the inputs just sampled.
   task automatic modelStep();
      if (mHalted) begin
         mHalted = 1'b1;
      end else if (!mIssuing) begin
         if (imem_ack) begin
            mF       = refDecode(imem_rdata);
            mPcOut   = mPc;
            mIssuing = 1'b1;
         end
      end else if (!stall) begin
         mIssuing = 1'b0;
`ifdef HALT_ON_ILLEGAL_EN
         if (mF.illegal) mHalted = 1'b1;
         else            mPc = mPc + 64'd4;
`else
         mPc = mPc + 64'd4;
`endif
      end
   endtask

   task automatic checkAll();
      checkOutput("imem_req",  64'(imem_req),  64'(rst_n && !mIssuing && !mHalted));
      checkOutput("imem_addr", imem_addr,      mPc);
      checkOutput("dec_valid", 64'(dec_valid), 64'(mIssuing));
      checkOutput("rs1",       64'(register_1), 64'(mF.rs1));
      checkOutput("rs2",       64'(register_2), 64'(mF.rs2));
      checkOutput("rd",        64'(write_register), 64'(mF.rd));
      checkOutput("imm",       64'(imm),       64'(mF.imm));
      checkOutput("ALUSrc",    64'(ALUSrc),    64'(mF.aluSrc));
      checkOutput("RegWrite",  64'(RegWrite),  64'(mF.regWrite));
      checkOutput("ALU_CO",    64'(ALU_CO),    64'(mF.aluCo));
      checkOutput("pc_out",    pc_out,         mPcOut);
      checkOutput("illegal",   64'(illegal_instr), 64'(mF.illegal));
      checkOutput("wrap_addr", wImemAddr,      mPc + WRAP_PC);
      checkOutput("wrap_pcout", wPcOut,        mPcOut + WRAP_PC);
      checkOutput("wrap_req",  64'(wImemReq),  64'(rst_n && !mIssuing && !mHalted));
   endtask

   task automatic applyStimulus(input logic ack, input logic stl, input logic [31:0] word);
      imem_ack   = ack;
      stall      = stl;
      imem_rdata = word;
   endtask

   // One clock: drive inputs after a falling edge, step the model at the
   // rising edge, compare at the next falling edge.
   task automatic runCycle(input logic ack, input logic stl, input logic [31:0] word);
      applyStimulus(ack, stl, word);
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   // Asynchronous reset pulse starting mid-cycle; outputs must clear before
   // the next clock edge, and fetching restarts from RESET_PC on release.
   task automatic pulseReset();
      #2 rst_n = 1'b0;
      #1 modelReset();
      checkAll();
      @(negedge clk);
      checkAll();
      rst_n = 1'b1;
      #1 checkAll();
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0);
      modelReset();
      @(negedge clk);
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;
      #1 checkAll();

      // ADD x3,x1,x2 then ADDI x5,x0,-1 with a constant acknowledge;
      // the acknowledge during the issue slot carries junk that must be ignored.
      runCycle(1'b1, 1'b0, makeR(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
      runCycle(1'b1, 1'b0, 32'hDEAD_BEEF);
      runCycle(1'b1, 1'b0, makeI(12'hFFF, 5'd0, 3'd0, 5'd5));
      runCycle(1'b1, 1'b0, 32'h0000_0033);

      // SUB held in the issue slot by a three-cycle stall.
      runCycle(1'b1, 1'b1, makeR(7'h20, 5'd6, 5'd4, 3'd0, 5'd7));
      for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1, $urandom);
      runCycle(1'b0, 1'b0, 32'd0);

      // Memory withholds the acknowledge for five cycles.
      for (int i = 0; i < 5; i++) runCycle(1'b0, 1'b0, $urandom);

      // ADD x0,x1,x2: legal, but no write-back.
      runCycle(1'b1, 1'b0, makeR(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
      runCycle(1'b0, 1'b0, 32'd0);

      // Reset pulse while an AND sits in the issue slot.
      runCycle(1'b1, 1'b1, makeR(7'h00, 5'd9, 5'd8, 3'd7, 5'd10));
      pulseReset();

      // Load opcode is unsupported; then try to continue fetching.
      runCycle(1'b1, 1'b0, 32'h0000_0003);
      runCycle(1'b0, 1'b0, 32'd0);
      runCycle(1'b1, 1'b0, makeI(12'h123, 5'd4, 3'd6, 5'd8));
      runCycle(1'b0, 1'b0, 32'd0);
      runCycle(1'b1, 1'b0, makeR(7'h00, 5'd3, 5'd2, 3'd4, 5'd1));
      pulseReset();

      // Random traffic with occasional asynchronous resets.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 59) == 0)
            pulseReset();
         else
            runCycle(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                     genWord());
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
